bellek_hakemi: RTL and testbench

Arbiter that shares the single main-memory port between the instruction-cache refill path (buyruk) and the data-cache refill/writeback path (veri). It sits below both caches, serialises their block transactions onto the memory port with at most one outstanding transaction, and keeps veri from starving buyruk. It also supports cancellation of an in-flight instruction fetch on a fetch-stage redirect (branch mispredict or jal).

---
 rtl/bellek_hakemi.sv | 180 ++++++++++++++++++
 tb/tb_bellek_hakemi.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: shares the single main-memory port between the instruction-cache
// refill path (buyruk) and the data-cache refill/writeback path (veri).
// One transaction outstanding at a time; veri is preferred but may win at most
// MAKS_ARDISIK times in a row while buyruk waits. A buyruk fetch may be cancelled
// (b_iptal_i) on a fetch redirect; the memory transaction still completes but its
// response is swallowed.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   b_istek_i/b_adres_i/b_iptal_i    buyruk read request, block address, cancel
//   b_kabul_o/b_gecerli_o/b_veri_o   buyruk accept pulse, data-valid pulse, data
//   v_istek_i/v_yaz_i/v_adres_i/
//   v_yaz_veri_i                     veri request, write flag, address, write data
//   v_kabul_o/v_gecerli_o/v_veri_o   veri accept pulse, valid/ack pulse, read data
//   m_istek_o/m_yaz_o/m_adres_o/
//   m_yaz_veri_o                     memory request, write flag, address, write data
//   m_hazir_i/m_gecerli_i/m_veri_i   memory accept, response valid, read data
//   mesgul_o                         arbiter busy (not idle)
module bellek_hakemi #(
  parameter int unsigned BLOK_GENISLIGI = 128,
  parameter int unsigned MAKS_ARDISIK   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      b_istek_i,
  input  logic [31:0]               b_adres_i,
  input  logic                      b_iptal_i,
  output logic                      b_kabul_o,
  output logic                      b_gecerli_o,
  output logic [BLOK_GENISLIGI-1:0] b_veri_o,
  input  logic                      v_istek_i,
  input  logic                      v_yaz_i,
  input  logic [31:0]               v_adres_i,
  input  logic [BLOK_GENISLIGI-1:0] v_yaz_veri_i,
  output logic                      v_kabul_o,
  output logic                      v_gecerli_o,
  output logic [BLOK_GENISLIGI-1:0] v_veri_o,
  output logic                      m_istek_o,
  output logic                      m_yaz_o,
  output logic [31:0]               m_adres_o,
  output logic [BLOK_GENISLIGI-1:0] m_yaz_veri_o,
  input  logic                      m_hazir_i,
  input  logic                      m_gecerli_i,
  input  logic [BLOK_GENISLIGI-1:0] m_veri_i,
  output logic                      mesgul_o
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;

  localparam logic SahipBuyruk = 1'b0;
  localparam logic SahipVeri   = 1'b1;

  logic [1:0]                durum_q, durum_d;
  logic                      sahip_q, sahip_d;
  logic [31:0]               adres_q, adres_d;
  logic                      yaz_q, yaz_d;
  logic [BLOK_GENISLIGI-1:0] yaz_veri_q, yaz_veri_d;
  logic [2:0]                sayac_q, sayac_d;
  logic                      iptal_q, iptal_d;
  logic                      b_gecerli_q, b_gecerli_d;
  logic                      v_gecerli_q, v_gecerli_d;
  logic [BLOK_GENISLIGI-1:0] b_veri_q, b_veri_d;
  logic [BLOK_GENISLIGI-1:0] v_veri_q, v_veri_d;

  logic ardisik_doldu;
  logic iptal_al;
  logic istek_faz;

  assign ardisik_doldu = 32'(sayac_q) >= MAKS_ARDISIK;
  // Cancel only applies to a transaction buyruk owns.
  assign iptal_al      = b_iptal_i && (sahip_q == SahipBuyruk);
  assign istek_faz     = (durum_q == ISTEK);

  always_comb begin
    durum_d     = durum_q;
    sahip_d     = sahip_q;
    adres_d     = adres_q;
    yaz_d       = yaz_q;
    yaz_veri_d  = yaz_veri_q;
    sayac_d     = sayac_q;
    iptal_d     = iptal_q;
    b_veri_d    = b_veri_q;
    v_veri_d    = v_veri_q;
    b_gecerli_d = 1'b0;
    v_gecerli_d = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        iptal_d = 1'b0;
        if (b_istek_i || v_istek_i) begin
          durum_d = ISTEK;
          if (b_istek_i && v_istek_i) begin
            if (ardisik_doldu) begin
              sahip_d = SahipBuyruk;
              sayac_d = 3'd0;
            end else begin
              sahip_d = SahipVeri;
              sayac_d = (sayac_q == 3'd7) ? sayac_q : sayac_q + 3'd1;
            end
          end else if (b_istek_i) begin
            sahip_d = SahipBuyruk;
            sayac_d = 3'd0;
          end else begin
            sahip_d = SahipVeri;
          end
          // Fields are frozen here until the transaction returns to BOSTA.
          adres_d    = (sahip_d == SahipBuyruk) ? b_adres_i : v_adres_i;
          yaz_d      = (sahip_d == SahipVeri) && v_yaz_i;
          yaz_veri_d = v_yaz_veri_i;
        end
      end
      ISTEK: begin
        if (iptal_al) iptal_d = 1'b1;
        if (m_hazir_i) durum_d = YANIT;
      end
      YANIT: begin
        if (iptal_al) iptal_d = 1'b1;
        if (m_gecerli_i) begin
          durum_d = BOSTA;
          iptal_d = 1'b0;
          if (sahip_q == SahipBuyruk) begin
            // A cancel arriving together with the response still swallows it.
            if (!(iptal_q || b_iptal_i)) begin
              b_gecerli_d = 1'b1;
              b_veri_d    = m_veri_i;
            end
          end else begin
            v_gecerli_d = 1'b1;
            if (!yaz_q) v_veri_d = m_veri_i;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      sahip_q     <= SahipBuyruk;
      adres_q     <= '0;
      yaz_q       <= 1'b0;
      yaz_veri_q  <= '0;
      sayac_q     <= 3'd0;
      iptal_q     <= 1'b0;
      b_gecerli_q <= 1'b0;
      v_gecerli_q <= 1'b0;
      b_veri_q    <= '0;
      v_veri_q    <= '0;
    end else begin
      durum_q     <= durum_d;
      sahip_q     <= sahip_d;
      adres_q     <= adres_d;
      yaz_q       <= yaz_d;
      yaz_veri_q  <= yaz_veri_d;
      sayac_q     <= sayac_d;
      iptal_q     <= iptal_d;
      b_gecerli_q <= b_gecerli_d;
      v_gecerli_q <= v_gecerli_d;
      b_veri_q    <= b_veri_d;
      v_veri_q    <= v_veri_d;
    end
  end

  assign m_istek_o    = istek_faz;
  assign m_yaz_o      = istek_faz && yaz_q;
  assign m_adres_o    = adres_q;
  assign m_yaz_veri_o = yaz_veri_q;

  assign b_kabul_o    = istek_faz && m_hazir_i && (sahip_q == SahipBuyruk);
  assign v_kabul_o    = istek_faz && m_hazir_i && (sahip_q == SahipVeri);
  assign b_gecerli_o  = b_gecerli_q;
  assign v_gecerli_o  = v_gecerli_q;
  assign b_veri_o     = b_veri_q;
  assign v_veri_o     = v_veri_q;
  assign mesgul_o     = (durum_q != BOSTA);

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: directed scenarios followed by random traffic, checked
// against a transaction-level reference model (winner choice, data, pulses).
module tb_bellek_hakemi;

  localparam int unsigned BW   = 128;
  localparam int unsigned MAKS = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          b_istek_i, b_iptal_i, v_istek_i, v_yaz_i;
  logic [31:0]   b_adres_i, v_adres_i;
  logic [BW-1:0] v_yaz_veri_i, m_veri_i;
  logic          m_hazir_i, m_gecerli_i;
  logic          b_kabul_o, b_gecerli_o, v_kabul_o, v_gecerli_o;
  logic          m_istek_o, m_yaz_o, mesgul_o;
  logic [31:0]   m_adres_o;
  logic [BW-1:0] b_veri_o, v_veri_o, m_yaz_veri_o;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int            sayac_m = 0;
  logic [BW-1:0] mb_veri = '0;
  logic [BW-1:0] mv_veri = '0;
  bit            late_v  = 1'b0;
  bit            scramble = 1'b0;

  always #5 clk = ~clk;

  bellek_hakemi #(
    .BLOK_GENISLIGI(BW),
    .MAKS_ARDISIK  (MAKS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .b_istek_i   (b_istek_i),
    .b_adres_i   (b_adres_i),
    .b_iptal_i   (b_iptal_i),
    .b_kabul_o   (b_kabul_o),
    .b_gecerli_o (b_gecerli_o),
    .b_veri_o    (b_veri_o),
    .v_istek_i   (v_istek_i),
    .v_yaz_i     (v_yaz_i),
    .v_adres_i   (v_adres_i),
    .v_yaz_veri_i(v_yaz_veri_i),
    .v_kabul_o   (v_kabul_o),
    .v_gecerli_o (v_gecerli_o),
    .v_veri_o    (v_veri_o),
    .m_istek_o   (m_istek_o),
    .m_yaz_o     (m_yaz_o),
    .m_adres_o   (m_adres_o),
    .m_yaz_veri_o(m_yaz_veri_o),
    .m_hazir_i   (m_hazir_i),
    .m_gecerli_i (m_gecerli_i),
    .m_veri_i    (m_veri_i),
    .mesgul_o    (mesgul_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs set afterwards apply to the new cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_m_istek"}, m_istek_o, 1'b0);
    chk1({tag, "_m_yaz"}, m_yaz_o, 1'b0);
    chk1({tag, "_pulses"}, b_kabul_o | b_gecerli_o | v_kabul_o | v_gecerli_o, 1'b0);
    chk1({tag, "_mesgul"}, mesgul_o, 1'b0);
    chkw({tag, "_b_veri"}, b_veri_o, '0);
    chkw({tag, "_v_veri"}, v_veri_o, '0);
    chkw({tag, "_m_adres"}, BW'(m_adres_o), '0);
    chkw({tag, "_m_yaz_veri"}, m_yaz_veri_o, '0);
  endtask

  // Runs one full transaction starting in an idle cycle with requests already driven.
  // hw/gw: memory wait cycles before m_hazir_i / m_gecerli_i. iptal_at: cycle index
  // (0 = first ISTEK cycle) at which b_iptal_i is pulsed, -1 for none.
  task automatic txn(input int hw, input int gw, input logic [BW-1:0] rdata,
                     input int iptal_at, input bit spur, output byte got, output bit own_b);
    logic          yaz;
    logic [31:0]   adr;
    logic [BW-1:0] wd;
    bit            canc;
    int            k;
    // Veri is preferred until buyruk has watched MAKS consecutive veri grants.
    if (b_istek_i && v_istek_i) begin
      if (sayac_m >= MAKS) begin
        own_b = 1'b1; sayac_m = 0;
      end else begin
        own_b = 1'b0; sayac_m = (sayac_m + 1 > 7) ? 7 : sayac_m + 1;
      end
    end else if (b_istek_i) begin
      own_b = 1'b1; sayac_m = 0;
    end else begin
      own_b = 1'b0;
    end
    yaz  = own_b ? 1'b0 : v_yaz_i;
    adr  = own_b ? b_adres_i : v_adres_i;
    wd   = v_yaz_veri_i;
    got  = "?";
    canc = 1'b0;
    k    = 0;
    #1;
    chk1("bosta_mesgul", mesgul_o, 1'b0);
    tick();
    for (int i = 0; i <= hw; i++) begin
      m_hazir_i   = (i == hw);
      m_gecerli_i = spur && (i < hw);
      b_iptal_i   = (k == iptal_at);
      if (own_b && b_iptal_i) canc = 1'b1;
      if (i == 0 && late_v) v_istek_i = 1'b1;
      if (i == 1 && scramble) begin
        v_adres_i    = ~v_adres_i;
        v_yaz_veri_i = ~v_yaz_veri_i;
        v_yaz_i      = ~v_yaz_i;
      end
      #1;
      chk1("istek_m_istek", m_istek_o, 1'b1);
      chkw("istek_adres", BW'(m_adres_o), BW'(adr));
      chk1("istek_yaz", m_yaz_o, yaz);
      if (yaz) chkw("istek_yaz_veri", m_yaz_veri_o, wd);
      chk1("istek_b_kabul", b_kabul_o, own_b && (i == hw));
      chk1("istek_v_kabul", v_kabul_o, !own_b && (i == hw));
      chk1("istek_gecerli", b_gecerli_o | v_gecerli_o, 1'b0);
      if (i == hw) got = b_kabul_o ? "B" : (v_kabul_o ? "V" : "?");
      k++;
      tick();
    end
    m_hazir_i = 1'b0;
    for (int j = 0; j <= gw; j++) begin
      m_gecerli_i = (j == gw);
      m_veri_i    = rdata;
      b_iptal_i   = (k == iptal_at);
      if (own_b && b_iptal_i) canc = 1'b1;
      #1;
      chk1("yanit_m_istek", m_istek_o, 1'b0);
      chk1("yanit_kabul", b_kabul_o | v_kabul_o, 1'b0);
      chk1("yanit_gecerli", b_gecerli_o | v_gecerli_o, 1'b0);
      chk1("yanit_mesgul", mesgul_o, 1'b1);
      k++;
      tick();
    end
    m_gecerli_i = 1'b0;
    b_iptal_i   = 1'b0;
    m_veri_i    = {$urandom, $urandom, $urandom, $urandom};
    if (own_b && !canc) mb_veri = rdata;
    if (!own_b && !yaz) mv_veri = rdata;
    #1;
    chk1("son_b_gecerli", b_gecerli_o, own_b && !canc);
    chk1("son_v_gecerli", v_gecerli_o, !own_b);
    chkw("son_b_veri", b_veri_o, mb_veri);
    if (!own_b && !yaz) chkw("son_v_veri", v_veri_o, mv_veri);
    chk1("son_mesgul", mesgul_o, 1'b0);
  endtask

  initial begin
    byte         got;
    bit          own_b;
    logic [79:0] sira_gor;
    logic [79:0] sira_bek;
    logic [7:0]  ch_b;
    logic [7:0]  ch_v;
    int          hw, gw, iptal_at;
    ch_b = "B";
    ch_v = "V";

    rst_i = 1'b1;
    b_istek_i = 1'b0; b_adres_i = '0; b_iptal_i = 1'b0;
    v_istek_i = 1'b0; v_yaz_i = 1'b0; v_adres_i = '0; v_yaz_veri_i = '0;
    m_hazir_i = 1'b0; m_gecerli_i = 1'b0; m_veri_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk_zero("reset");

    // Lone buyruk read, zero wait states.
    b_istek_i = 1'b1; b_adres_i = 32'h0000_1000;
    txn(0, 0, {16{8'hA5}}, -1, 1'b0, got, own_b);
    chkw("lone_b_grant", BW'(got), BW'(ch_b));
    b_istek_i = 1'b0;

    // Veri write, memory accept delayed 3 cycles; requester inputs disturbed mid-way.
    v_istek_i = 1'b1; v_yaz_i = 1'b1; v_adres_i = 32'h0000_2000;
    v_yaz_veri_i = {8{16'h1234}};
    scramble = 1'b1;
    txn(3, 1, {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, got, own_b);
    chkw("write_grant", BW'(got), BW'(ch_v));
    scramble = 1'b0;
    v_istek_i = 1'b0; v_yaz_i = 1'b0;

    // Both requesting continuously.
    b_istek_i = 1'b1; b_adres_i = 32'h0000_0100;
    v_istek_i = 1'b1; v_adres_i = 32'h0000_0200;
    sira_gor = '0;
    sira_bek = "VVVVBVVVVB";
    for (int n = 0; n < 10; n++) begin
      txn(0, 0, {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, got, own_b);
      sira_gor = {sira_gor[71:0], got};
    end
    chkw("grant_order", BW'(sira_gor), BW'(sira_bek));
    b_istek_i = 1'b0; v_istek_i = 1'b0;

    // Cancel the cycle after b_kabul_o; veri raises a request meanwhile.
    b_istek_i = 1'b1; b_adres_i = 32'h0000_3000;
    v_adres_i = 32'h0000_4000; v_yaz_i = 1'b0;
    late_v = 1'b1;
    txn(0, 2, {16{8'h5A}}, 1, 1'b0, got, own_b);
    late_v = 1'b0;
    b_istek_i = 1'b0;
    txn(0, 0, {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, got, own_b);
    chkw("after_cancel_grant", BW'(got), BW'(ch_v));
    v_istek_i = 1'b0;

    // Spurious response and cancel while idle.
    m_gecerli_i = 1'b1; b_iptal_i = 1'b1;
    tick();
    m_gecerli_i = 1'b0; b_iptal_i = 1'b0;
    #1;
    chk1("spur_bosta_gecerli", b_gecerli_o | v_gecerli_o, 1'b0);
    chk1("spur_bosta_mesgul", mesgul_o, 1'b0);
    chk1("spur_bosta_m_istek", m_istek_o, 1'b0);

    // Spurious response during ISTEK.
    b_istek_i = 1'b1; b_adres_i = 32'h0000_7000;
    txn(2, 1, {$urandom, $urandom, $urandom, $urandom}, -1, 1'b1, got, own_b);
    b_istek_i = 1'b0;

    // Reset while waiting in YANIT.
    b_istek_i = 1'b1; b_adres_i = 32'h0000_5000;
    tick();
    m_hazir_i = 1'b1;
    #1;
    chk1("rst_pre_kabul", b_kabul_o, 1'b1);
    tick();
    m_hazir_i = 1'b0; b_istek_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk_zero("rst_yanit");
    sayac_m = 0; mb_veri = '0; mv_veri = '0;
    b_istek_i = 1'b1; b_adres_i = 32'h0000_6000;
    txn(1, 1, {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, got, own_b);
    chkw("post_reset_grant", BW'(got), BW'(ch_b));
    b_istek_i = 1'b0;

    // Random traffic; a losing request stays pending until it is granted.
    for (int t = 0; t < 60; t++) begin
      if (!b_istek_i && $urandom_range(0, 1) == 1) begin
        b_istek_i = 1'b1; b_adres_i = $urandom;
      end
      if (!v_istek_i && $urandom_range(0, 1) == 1) begin
        v_istek_i = 1'b1; v_adres_i = $urandom; v_yaz_i = 1'($urandom_range(0, 1));
        v_yaz_veri_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!b_istek_i && !v_istek_i) begin
        b_istek_i = 1'b1; b_adres_i = $urandom;
      end
      hw = int'($urandom_range(0, 2));
      gw = int'($urandom_range(0, 2));
      iptal_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, hw + gw + 1)) : -1;
      txn(hw, gw, {$urandom, $urandom, $urandom, $urandom}, iptal_at,
          ($urandom_range(0, 3) == 0), got, own_b);
      if (own_b) b_istek_i = 1'b0;
      else v_istek_i = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
